// File: rtl/kernel_dispatcher_pkg.sv
// Shared GPU definitions: dispatcher/slot state encodings and the thread-count
// width used by the device control register.
package kernel_dispatcher_pkg;

    localparam int THREAD_COUNT_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        RUN,
        DONE
    } dispatch_state_t;

    typedef enum logic {
        FREE,
        BUSY
    } slot_state_t;

endpackage

// File: rtl/kernel_dispatcher.sv
// Splits a kernel's thread count into fixed-size blocks and hands them out,
// at most one per cycle, to the lowest-index free compute core.
//
// state | meaning
// IDLE  | waiting for start; latches thread_count and clears the counters
// INIT  | one-cycle reset pulse to every core
// RUN   | dispatching blocks and retiring completed ones
// DONE  | every block retired; held until start drops
module kernel_dispatcher
    import kernel_dispatcher_pkg::*;
#(
    parameter int NUM_CORES         = 2,
    parameter int THREADS_PER_BLOCK = 4,
    localparam int CTW              = $clog2(THREADS_PER_BLOCK) + 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [THREAD_COUNT_W-1:0]   thread_count,
    input  logic [NUM_CORES-1:0]        core_done,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [NUM_CORES-1:0]        core_reset,
    output logic [NUM_CORES*8-1:0]      core_block_id,
    output logic [NUM_CORES*CTW-1:0]    core_thread_count,
    output logic                        done
);

    localparam int          LOG2_TPB = $clog2(THREADS_PER_BLOCK);
    localparam logic [8:0]  TPB_M1   = 9'(THREADS_PER_BLOCK - 1);
    localparam logic [15:0] TPB_W    = 16'(THREADS_PER_BLOCK);

    dispatch_state_t             state_q, state_d;
    logic [THREAD_COUNT_W-1:0]   tc_q, tc_d;
    logic [7:0]                  dispatched_q, dispatched_d;
    logic [7:0]                  retired_q, retired_d;
    logic                        done_q, done_d;

    logic [7:0]                  total_blocks;
    logic [15:0]                 remaining;
    logic [CTW-1:0]              block_threads;
    logic                        launch;
    logic                        dispatch_ok;
    logic [NUM_CORES-1:0]        eligible;
    logic [NUM_CORES-1:0]        retire;
    logic [NUM_CORES-1:0]        grant;
    logic [7:0]                  n_retire;
    logic [7:0]                  retired_next;

    function automatic logic [NUM_CORES-1:0] pick_lowest(input logic [NUM_CORES-1:0] req);
        logic [NUM_CORES-1:0] gnt;
        logic                 found;
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (req[k] && !found) begin
                gnt[k] = 1'b1;
                found  = 1'b1;
            end
        end
        return gnt;
    endfunction

    function automatic logic [7:0] count_ones(input logic [NUM_CORES-1:0] v);
        logic [7:0] n;
        n = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            n = n + 8'(v[k]);
        end
        return n;
    endfunction

    // Block size arithmetic; the last block may be partial.
    always_comb begin
        total_blocks  = 8'(({1'b0, tc_q} + TPB_M1) >> LOG2_TPB);
        remaining     = 16'(tc_q) - (16'(dispatched_q) << LOG2_TPB);
        block_threads = (remaining >= TPB_W) ? CTW'(THREADS_PER_BLOCK) : CTW'(remaining);
        launch        = (state_q == IDLE) && start;
        dispatch_ok   = (state_q == RUN) && (dispatched_q < total_blocks) && (|eligible);
        grant         = dispatch_ok ? pick_lowest(eligible) : '0;
        n_retire      = count_ones(retire);
        retired_next  = retired_q + n_retire;
    end

    always_comb begin
        state_d      = state_q;
        tc_d         = tc_q;
        dispatched_d = dispatched_q;
        retired_d    = retired_q;
        done_d       = done_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    tc_d         = thread_count;
                    dispatched_d = '0;
                    retired_d    = '0;
                    state_d      = INIT;
                end
            end
            INIT: begin
                if (total_blocks == 8'd0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (dispatch_ok) begin
                    dispatched_d = dispatched_q + 8'd1;
                end
                retired_d = retired_next;
                if (retired_next == total_blocks) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end
            end
            DONE: begin
                if (!start) begin
                    state_d = IDLE;
                    done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            tc_q         <= '0;
            dispatched_q <= '0;
            retired_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tc_q         <= tc_d;
            dispatched_q <= dispatched_d;
            retired_q    <= retired_d;
            done_q       <= done_d;
        end
    end

    assign done = done_q;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_slot
        slot_state_t    slot_q, slot_d;
        logic           core_reset_q, core_reset_d;
        logic [7:0]     block_id_q, block_id_d;
        logic [CTW-1:0] thr_cnt_q, thr_cnt_d;

        // A core still in its reset pulse cannot take a block this cycle.
        assign eligible[i] = (slot_q == FREE) && !core_reset_q;
        assign retire[i]   = (state_q == RUN) && (slot_q == BUSY) && core_done[i];

        always_comb begin
            slot_d       = slot_q;
            core_reset_d = 1'b0;
            block_id_d   = block_id_q;
            thr_cnt_d    = thr_cnt_q;
            if (launch) begin
                core_reset_d = 1'b1;
            end
            if (retire[i]) begin
                slot_d       = FREE;
                core_reset_d = 1'b1;
            end else if (grant[i]) begin
                slot_d     = BUSY;
                block_id_d = dispatched_q;
                thr_cnt_d  = block_threads;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                slot_q       <= FREE;
                core_reset_q <= 1'b0;
                block_id_q   <= '0;
                thr_cnt_q    <= '0;
            end else begin
                slot_q       <= slot_d;
                core_reset_q <= core_reset_d;
                block_id_q   <= block_id_d;
                thr_cnt_q    <= thr_cnt_d;
            end
        end

        assign core_start[i]                   = (slot_q == BUSY);
        assign core_reset[i]                   = core_reset_q;
        assign core_block_id[i*8 +: 8]         = block_id_q;
        assign core_thread_count[i*CTW +: CTW] = thr_cnt_q;
    end

endmodule

// File: tb/tb_kernel_dispatcher.sv
// Kernel dispatcher bench: emulated cores with random latencies, checked
// against a block-list model of the kernel launch.
module tb_kernel_dispatcher;

    localparam int NC  = 2;
    localparam int TPB = 4;
    localparam int CTW = 3;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 start;
    logic [7:0]           thread_count;
    logic [NC-1:0]        core_done;
    logic [NC-1:0]        core_start;
    logic [NC-1:0]        core_reset;
    logic [NC*8-1:0]      core_block_id;
    logic [NC*CTW-1:0]    core_thread_count;
    logic                 done;

    kernel_dispatcher #(.NUM_CORES(NC), .THREADS_PER_BLOCK(TPB)) dut (
        .clk              (clk),
        .reset            (reset),
        .start            (start),
        .thread_count     (thread_count),
        .core_done        (core_done),
        .core_start       (core_start),
        .core_reset       (core_reset),
        .core_block_id    (core_block_id),
        .core_thread_count(core_thread_count),
        .done             (done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int            lat_fix [NC];
    int            cnt     [NC];
    logic [NC-1:0] prev_start, prev_reset, prev_done;
    int            blk_core [256];
    int            last_thr;
    int            max_simul;
    int            n_dispatched;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Emulated cores: raise core_done a few cycles after being started, hold it
    // until the dispatcher frees the core; optionally chatter while free.
    task automatic drive_cores(input int spurious);
        for (int i = 0; i < NC; i++) begin
            if (core_start[i]) begin
                if (!prev_start[i])
                    cnt[i] = (lat_fix[i] > 0) ? lat_fix[i] : int'($urandom_range(1, 6));
                if (cnt[i] > 0) cnt[i]--;
                core_done[i] = (cnt[i] == 0);
            end else begin
                core_done[i] = (spurious != 0) && ($urandom_range(0, 7) == 0);
            end
        end
    endtask

    task automatic run_kernel(input int tc, input int spurious);
        int nblocks, exp_next, retired, nret, exp_core, exp_thr, rem;
        logic finished;
        logic rose;
        nblocks      = (tc + TPB - 1) / TPB;
        exp_next     = 0;
        retired      = 0;
        max_simul    = 0;
        n_dispatched = 0;
        last_thr     = -1;
        finished     = 1'b0;
        thread_count = 8'(tc);
        start        = 1'b1;
        tick();
        chk("init_reset", 32'(core_reset), 32'({NC{1'b1}}));
        chk("init_start", 32'(core_start), 0);
        chk("init_done", 32'(done), 0);
        thread_count = 8'($urandom);
        core_done    = '0;
        prev_start   = core_start;
        prev_reset   = core_reset;
        prev_done    = '0;
        for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
            tick();
            nret = 0;
            for (int i = 0; i < NC; i++) begin
                if (prev_start[i] && prev_done[i]) begin
                    nret++;
                    chk("retire_start", 32'(core_start[i]), 0);
                    chk("retire_reset", 32'(core_reset[i]), 1);
                end else begin
                    chk("no_reset", 32'(core_reset[i]), 0);
                end
            end
            retired += nret;
            if (nret > max_simul) max_simul = nret;
            exp_core = -1;
            if (exp_next < nblocks) begin
                for (int i = NC - 1; i >= 0; i--)
                    if (!prev_start[i] && !prev_reset[i]) exp_core = i;
            end
            for (int i = 0; i < NC; i++) begin
                rose = core_start[i] && !prev_start[i];
                if (i == exp_core) begin
                    rem     = tc - exp_next * TPB;
                    exp_thr = (rem < TPB) ? rem : TPB;
                    chk("dispatch_core", 32'(rose), 1);
                    chk("block_id", 32'(core_block_id[i*8 +: 8]), 32'(exp_next));
                    chk("thr_cnt", 32'(core_thread_count[i*CTW +: CTW]), 32'(exp_thr));
                    blk_core[exp_next] = i;
                    last_thr = int'(core_thread_count[i*CTW +: CTW]);
                end else begin
                    chk("no_dispatch", 32'(rose), 0);
                end
                if (rose) n_dispatched++;
            end
            if (exp_core >= 0) exp_next++;
            chk("done", 32'(done), 32'(retired == nblocks));
            if (done) finished = 1'b1;
            drive_cores(spurious);
            prev_start = core_start;
            prev_reset = core_reset;
            prev_done  = core_done;
        end
        chk("finished", 32'(finished), 1);
        chk("dispatched_total", 32'(n_dispatched), 32'(nblocks));
        core_done = '0;
        tick();
        chk("done_hold", 32'(done), 1);
        chk("hold_start", 32'(core_start), 0);
        chk("hold_reset", 32'(core_reset), 0);
        start = 1'b0;
        tick();
        chk("done_fall", 32'(done), 0);
    endtask

    initial begin
        reset        = 1'b0;
        start        = 1'b0;
        thread_count = '0;
        core_done    = '0;
        prev_start   = '0;
        prev_reset   = '0;
        prev_done    = '0;
        for (int i = 0; i < NC; i++) begin
            lat_fix[i] = 0;
            cnt[i]     = 0;
        end
        #12;
        chk("rst_start", 32'(core_start), 0);
        chk("rst_reset", 32'(core_reset), 0);
        chk("rst_id", 32'(core_block_id), 0);
        chk("rst_thr", 32'(core_thread_count), 0);
        chk("rst_done", 32'(done), 0);
        reset = 1'b1;
        tick();
        chk("idle_done", 32'(done), 0);

        // 10 threads, cores finish 5 cycles after start
        lat_fix[0] = 5;
        lat_fix[1] = 5;
        run_kernel(10, 0);
        chk("blk2_core", 32'(blk_core[2]), 0);

        // empty kernel
        run_kernel(0, 0);

        // both cores finish together
        lat_fix[0] = 6;
        lat_fix[1] = 5;
        run_kernel(8, 0);
        chk("simul_retire", 32'(max_simul), 2);

        // maximum thread count
        lat_fix[0] = 0;
        lat_fix[1] = 0;
        run_kernel(255, 0);
        chk("last_thr_255", 32'(last_thr), 3);

        // single block with chatter on the idle core
        run_kernel(4, 1);

        // reset mid-kernel
        thread_count = 8'd40;
        start        = 1'b1;
        core_done    = '0;
        tick();
        for (int c = 0; c < 20 && core_start != {NC{1'b1}}; c++) tick();
        chk("both_busy", 32'(core_start), 32'({NC{1'b1}}));
        #2;
        reset = 1'b0;
        #1;
        chk("abort_start", 32'(core_start), 0);
        chk("abort_reset", 32'(core_reset), 0);
        chk("abort_id", 32'(core_block_id), 0);
        chk("abort_thr", 32'(core_thread_count), 0);
        chk("abort_done", 32'(done), 0);
        start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        chk("post_abort_reset", 32'(core_reset), 0);
        run_kernel(40, 1);

        // random kernels
        for (int k = 0; k < 6; k++) begin
            run_kernel(int'($urandom_range(0, 255)), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/kernel_dispatcher.md
# kernel_dispatcher

Launches a kernel across the GPU compute cores. On `start` it captures the thread count held in the device control register and splits it into blocks of `THREADS_PER_BLOCK` threads. It hands the blocks out one per cycle to free cores, resets each core between blocks, counts completions, and raises `done` when every block has retired. It sits between the device control register and the core array.

## Interface
- `NUM_CORES`, default 2: number of compute cores; must be ≥1.
- `THREADS_PER_BLOCK`, default 4: threads per block; must be a power of two, 1..128.
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-low; clock `clk`.
- `start` in 1: kernel launch request, level; the host holds it high until `done`.
- `thread_count` in 8: total threads, from the device control register.
- `core_done` in NUM_CORES: core i has finished its current block; level.
- `core_start` out NUM_CORES: core i is executing an assigned block.
- `core_reset` out NUM_CORES: one-cycle reset pulse to core i.
- `core_block_id` out NUM_CORES×8: block index assigned to core i.
- `core_thread_count` out NUM_CORES×($clog2(THREADS_PER_BLOCK)+1): active threads in the block assigned to core i.
- `done` out 1: kernel complete.

## Operation
- Top FSM states: IDLE, INIT, RUN, DONE.
- IDLE
  - On `start`=1: latch `thread_count` into `tc_q`.
  - `total_blocks` = (`tc_q` + TPB−1) >> log2(TPB). Compute in 9 bits; the result fits in 8.
  - Clear `dispatched` and `retired` (8-bit each), then go to INIT.
- INIT: all `core_reset` high for exactly one cycle.
  - Next state is RUN, or DONE if `total_blocks`==0.
- Per-core slot: FREE or BUSY. `core_start[i]` is 1 exactly when slot i is BUSY.
- RUN, dispatch
  - Condition: `dispatched` < `total_blocks` and at least one eligible slot.
  - Eligible slot: FREE, and `core_reset[i]` not high this cycle.
  - Action: the lowest-index eligible slot becomes BUSY.
  - That core gets `core_block_id[i]`=`dispatched` and `core_thread_count[i]` = min(TPB, `tc_q` − `dispatched`·TPB).
  - `dispatched` increments. At most one dispatch per cycle.
- RUN, retire
  - Condition: `core_done[i]`=1 while slot i is BUSY.
  - Action: slot goes FREE, `core_reset[i]` pulses high for the next cycle, `retired` increments by the number of cores retiring this cycle.
  - Several cores may retire in the same cycle.
  - `core_done` on a FREE slot is ignored.
- A retire and a dispatch in the same cycle are legal. The retiring slot is not eligible for dispatch that cycle.
- RUN → DONE when `retired` (including this cycle's retirements) equals `total_blocks`.
- DONE: `done`=1. When `start` goes to 0, return to IDLE and drop `done`.
- `core_block_id` and `core_thread_count` hold their values after retire until the next dispatch to that core.

## Timing
- Reset values: all outputs 0, all slots FREE, FSM in IDLE, counters 0.
- Reset mid-kernel aborts immediately with no drain. Restarting needs a new `start` edge after reset release.
- All outputs are registered.
- Launch sequence:
  - Edge E0 samples `start`=1 → INIT; `core_reset` is all ones during the E0–E1 cycle.
  - E1 → RUN.
  - E2: first dispatch, `core_start[0]`=1.
  - Each later edge E3, E4, … dispatches one more block while cores are free.
- Retire sampled at edge Ek:
  - `core_start[i]`=0 and `core_reset[i]`=1 after Ek.
  - Earliest redispatch of core i is at edge Ek+2.
- `done` rises at the edge that samples the final `core_done`.
- `thread_count` is ignored outside IDLE.

## Structure
- Shared GPU package holds:
  - `dispatch_state_t` enum (IDLE, INIT, RUN, DONE).
  - `slot_state_t` enum (FREE, BUSY).
  - `THREAD_COUNT_W`=8.
- No sub-module. Per-core slot logic is a generate loop. A priority encoder function picks the lowest eligible index.

## Test plan
- `thread_count`=10, TPB=4, 2 cores; cores finish 5 cycles after `core_start`.
  - Required: block_ids 0, 1, 2 with thread counts 4, 4, 2.
  - Block 2 goes to core 0 after its reset pulse.
  - `done` asserts after the third retire.
- `thread_count`=0.
  - Required: no `core_start` ever.
  - `core_reset` all ones for one cycle, then `done`=1 two edges after `start`.
- `thread_count`=8, both cores raise `core_done` in the same cycle.
  - Required: `retired` goes 0→2 and `done` asserts at that edge.
  - Both `core_reset` bits pulse together.
- `thread_count`=255, TPB=4, 2 cores.
  - Required: 64 blocks; the last has `core_thread_count`=3.
  - No counter wrap; `done` after 64 retires.
- `reset` low while 2 blocks are BUSY.
  - Required: all outputs 0 asynchronously and FSM in IDLE.
  - A new `start` relaunches from block 0.
- Spurious `core_done[1]` while core 1 is FREE.
  - Required: `retired` unchanged and no `core_reset` pulse.
- `start` dropped after `done`.
  - Required: `done` falls one cycle later.
  - `start` high again launches a second kernel.
